// File: rtl/move_average_win.sv
// Moving-average filter: mean of the last N = 2^LOG2_N accepted unsigned samples.
// Latency: one cycle from an accepted sample to data_out_valid/data_out (registered).
// Backpressure: none; accepts one sample per clock, the caller must not exceed that.
//
// Optional feature macro: MOVE_AVERAGE_ROUND_EN
//   defined   -> data_out = (sum + N/2) >> LOG2_N  (round half up)
//   undefined -> data_out = sum >> LOG2_N          (truncate)
//   Cycle timing is identical in both builds.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   enable         in   run enable; low flushes the block and holds it in IDLE
//   clear          in   synchronous flush pulse (wins over a coincident sample)
//   data_in_valid  in   sample strobe
//   data_in        in   unsigned sample, WIDTH bits
//   data_out_valid out  one-cycle strobe, one cycle after each accepted sample once N are held
//   data_out       out  windowed mean, held between strobes
//   window_full    out  high while N samples are held (RUN state)

module move_average_win #(
  parameter int WIDTH  = 8,  // sample/result width, 2..32
  parameter int LOG2_N = 4   // window length N = 2^LOG2_N, 1..6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             data_in_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             window_full
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = WIDTH + LOG2_N;  // running-sum width; N*(2^WIDTH-1)+N/2 fits

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [WIDTH-1:0]  sample_buf [N];
  logic [LOG2_N-1:0] wr_ptr;
  logic [LOG2_N-1:0] fill_cnt;
  logic [SW-1:0]     sum;
  logic [SW-1:0]     sum_nxt;
  logic [SW-1:0]     sum_rnd;
  logic [WIDTH-1:0]  avg_nxt;
  logic [LOG2_N-1:0] frac_unused;

  logic              flush;
  logic              accept;
  logic              last_fill;
  logic              out_vld_nxt;

  // Any flush (enable low or clear) returns everything to zero on the next edge.
  assign flush     = !enable || clear;
  // clear blocks acceptance, so a sample coinciding with clear is dropped.
  assign accept    = data_in_valid && enable && !clear;
  assign last_fill = (fill_cnt == LOG2_N'(N - 1));

  // Incremental update: the slot under wr_ptr holds the oldest sample (zero while
  // filling, since the buffer is flushed to zero), so no re-summation is needed.
  // Modular SW-bit arithmetic is exact because the true result always fits.
  assign sum_nxt = sum + {{LOG2_N{1'b0}}, data_in}
                       - {{LOG2_N{1'b0}}, sample_buf[wr_ptr]};

`ifdef MOVE_AVERAGE_ROUND_EN
  assign sum_rnd = sum_nxt + SW'(N / 2);
`else
  assign sum_rnd = sum_nxt;
`endif

  // The low LOG2_N bits are the fraction discarded by the divide-by-N shift.
  assign {avg_nxt, frac_unused} = sum_rnd;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and result strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    out_vld_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (clear) begin
      state_nxt = FILL;
    end else begin
      case (state)
        // A sample arriving with the enabling edge is already counted; N >= 2,
        // so it can never complete the window on its own.
        IDLE: state_nxt = FILL;
        FILL: begin
          if (accept && last_fill) begin
            state_nxt   = RUN;
            out_vld_nxt = 1'b1;
          end
        end
        RUN:     out_vld_nxt = accept;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: window buffer, running sum, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        sample_buf[i] <= '0;
      end
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      sum            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      window_full    <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) begin
        sample_buf[i] <= '0;
      end
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      sum            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      window_full    <= 1'b0;
    end else begin
      if (accept) begin
        sample_buf[wr_ptr] <= data_in;
        wr_ptr             <= wr_ptr + LOG2_N'(1);  // wraps N-1 -> 0 naturally
        sum                <= sum_nxt;
        if (state != RUN) begin
          fill_cnt <= fill_cnt + LOG2_N'(1);
        end
      end
      data_out_valid <= out_vld_nxt;
      if (out_vld_nxt) begin
        data_out <= avg_nxt;
      end
      // Registered copy of "next state is RUN", so it tracks the state register.
      window_full <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_move_average_win.sv
// Self-checking bench for move_average_win (WIDTH=8, LOG2_N=2).
// Directed window scenarios followed by randomized traffic, all compared
// against a queue-based reference model of the last N accepted samples.

module tb_move_average_win;

  localparam int WIDTH  = 8;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

`ifdef MOVE_AVERAGE_ROUND_EN
  localparam int RND     = N / 2;
  localparam int EXP_R31 = 1;
`else
  localparam int RND     = 0;
  localparam int EXP_R31 = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic             data_in_valid = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             data_out_valid;
  logic [WIDTH-1:0] data_out;
  logic             window_full;

  move_average_win #(
    .WIDTH  (WIDTH),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .clear          (clear),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .window_full    (window_full)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the accepted samples since the last flush (at most N).
  int win[$];
  int exp_dout;
  bit exp_vld;
  bit exp_full;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  function automatic void model_flush();
    win.delete();
    exp_dout = 0;
    exp_vld  = 1'b0;
    exp_full = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit clr, input bit v, input int d);
    int s;
    if (!en || clr) begin
      model_flush();
    end else if (v) begin
      win.push_back(d);
      if (win.size() > N) void'(win.pop_front());
      exp_vld  = (win.size() == N);
      exp_full = (win.size() == N);
      if (exp_vld) begin
        s = 0;
        foreach (win[i]) s += win[i];
        exp_dout = (s + RND) >> LOG2_N;
      end
    end else begin
      exp_vld  = 1'b0;
      exp_full = (win.size() == N);
    end
  endfunction

  // One clock: drive inputs, let the edge happen, update model, sample #1 later.
  task automatic cyc(input bit en, input bit clr, input bit v, input int d);
    enable        = en;
    clear         = clr;
    data_in_valid = v;
    data_in       = d[WIDTH-1:0];
    @(posedge clk);
    model_step(en, clr, v, d);
    #1;
    chk("vld",  data_out_valid, exp_vld);
    chk("full", window_full,    exp_full);
    chk("dout", data_out,       exp_dout);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld",  data_out_valid, 0);
    chk("rst_full", window_full,    0);
    chk("rst_dout", data_out,       0);
    model_flush();
    #3 rst_n = 1'b1;
  endtask

  initial begin
    model_flush();
    #12;
    chk("por_vld",  data_out_valid, 0);
    chk("por_full", window_full,    0);
    chk("por_dout", data_out,       0);
    rst_n = 1'b1;

    // Fill: 10,20,30,40 -> mean 25 on the 4th only.
    cyc(1, 0, 1, 10); chk("fill1_vld", data_out_valid, 0);
    cyc(1, 0, 1, 20); chk("fill2_vld", data_out_valid, 0);
    cyc(1, 0, 1, 30); chk("fill3_vld", data_out_valid, 0);
    cyc(1, 0, 1, 40);
    chk("avg4_dout", data_out, 25);
    chk("avg4_vld",  data_out_valid, 1);
    chk("avg4_full", window_full, 1);

    // Wrap: oldest drops out.
    cyc(1, 0, 1, 50); chk("avg50_dout", data_out, 35);
    cyc(1, 0, 1, 60); chk("avg60_dout", data_out, 45);

    // Idle cycles in RUN: strobe drops, value holds.
    cyc(1, 0, 0, 0);  chk("hold_vld", data_out_valid, 0);
    chk("hold_dout", data_out, 45);

    // Full scale, back to back.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 255);
      chk("max_vld", data_out_valid, 1);
    end
    chk("max_dout", data_out, 255);

    // Rounding corner: 1,1,1,0 -> sum 3.
    cyc(1, 0, 1, 1); cyc(1, 0, 1, 1); cyc(1, 0, 1, 1); cyc(1, 0, 1, 0);
    chk("round_dout", data_out, EXP_R31);

    // Clear with a coincident sample: dropped, then four new samples needed.
    cyc(1, 1, 1, 5);
    chk("clr_full", window_full, 0);
    chk("clr_vld",  data_out_valid, 0);
    chk("clr_dout", data_out, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 8 * (i + 1));
      chk("clr_fill_vld", data_out_valid, 0);
    end
    cyc(1, 0, 1, 100);
    chk("clr_refill_vld",  data_out_valid, 1);
    chk("clr_refill_dout", data_out, (8 + 16 + 24 + 100 + RND) / 4);

    // Enable low in RUN flushes; re-enable needs four samples.
    cyc(0, 0, 1, 77);
    chk("dis_vld",  data_out_valid, 0);
    chk("dis_full", window_full, 0);
    chk("dis_dout", data_out, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 200);
      chk("reen_vld", data_out_valid, 0);
    end
    cyc(1, 0, 1, 200);
    chk("reen_done_vld",  data_out_valid, 1);
    chk("reen_done_dout", data_out, 200);

    // Reset mid-stream.
    cyc(1, 0, 1, 3);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 40);
      chk("rst_refill_vld", data_out_valid, 0);
    end
    cyc(1, 0, 1, 40);
    chk("rst_refill_done", data_out_valid, 1);

    // Randomized traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      bit en;
      bit clr;
      bit v;
      int d;
      int r;
      en = ($urandom_range(0, 99) < 97);
      clr = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 75);
      r = $urandom_range(0, 7);
      if (r < 2) d = 255;
      else if (r == 2) d = 0;
      else d = $urandom_range(0, 255);
      cyc(en, clr, v, d);
      if ((it % 700) == 699) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/move_average_win.md
MOVE_AVERAGE_WIN -- requirements
Module: move_average_win

Interface
REQ-001 SHALL have parameter WIDTH, default 8, unsigned sample/result width (legal 2..32).
REQ-002 SHALL have parameter LOG2_N, default 4, window length N = 2^LOG2_N samples (legal 1..6).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, run enable; low flushes the block.
REQ-006 SHALL have port clear, input, 1, synchronous flush pulse.
REQ-007 SHALL have port data_in_valid, input, 1, sample strobe.
REQ-008 SHALL have port data_in, input, WIDTH, unsigned sample.
REQ-009 SHALL have port data_out_valid, output, 1, one-cycle result strobe.
REQ-010 SHALL have port data_out, output, WIDTH, windowed mean.
REQ-011 SHALL have port window_full, output, 1, high once N samples are held.

Function
REQ-012 SHALL store the last N accepted samples in a circular buffer with LOG2_N-bit write pointer that wraps N-1 -> 0.
REQ-013 SHALL keep a running sum of WIDTH+LOG2_N bits, updated per accepted sample as sum + data_in - oldest; no full re-summation.
REQ-014 SHALL accept a sample only when data_in_valid=1, enable=1 and clear=0.
REQ-015 SHALL implement states IDLE, FILL, RUN: IDLE->FILL on enable=1; FILL->RUN when Nth sample accepted; any state->IDLE on enable=0; FILL/RUN->FILL on clear=1 with enable=1.
REQ-016 SHALL in FILL count accepted samples 0..N-1 and treat unfilled buffer slots as zero.
REQ-017 SHALL assert data_out_valid exactly one cycle after each accepted sample in RUN, including the Nth sample completing FILL; never in IDLE or FILL.
REQ-018 SHALL present data_out = updated sum >> LOG2_N (see Configuration), registered with data_out_valid and held until the next valid.
REQ-019 SHALL assert window_full registered, high in RUN only.
REQ-020 SHALL on entering IDLE or on clear zero buffer, sum, pointer, count, data_out, data_out_valid and window_full the next cycle.
REQ-021 SHALL give clear priority over a coincident data_in_valid (sample dropped).
REQ-022 SHALL never overflow: max sum N*(2^WIDTH-1) (+N/2 when rounding) fits WIDTH+LOG2_N bits; result ≤ 2^WIDTH-1.
REQ-023 SHALL sustain one sample per clock (back-to-back data_in_valid) without loss.

Reset
REQ-024 SHALL on rst_n=0 asynchronously force state IDLE, buffer, sum, pointer, count to 0, data_out=0, data_out_valid=0, window_full=0.
REQ-025 SHALL after mid-operation reset require N fresh samples before next data_out_valid.

Configuration
REQ-026 SHALL with MOVE_AVERAGE_ROUND_EN defined compute data_out = (sum + 2^(LOG2_N-1)) >> LOG2_N (round half up).
REQ-027 SHALL without MOVE_AVERAGE_ROUND_EN compute data_out = sum >> LOG2_N (truncate); cycle timing identical either way.

Verification (WIDTH=8, LOG2_N=2)
REQ-028 SHALL cover: enable=1, samples 10,20,30,40 -> no valid for first three; one cycle after 40 data_out=25, data_out_valid=1, window_full=1.
REQ-029 SHALL cover: then sample 50 -> data_out=35; then 60 -> 45 (buffer wrap, oldest dropped).
REQ-030 SHALL cover: four back-to-back samples of 255 -> data_out=255, no overflow, four consecutive valid cycles once full.
REQ-031 SHALL cover: samples 1,1,1,0 -> data_out=1 with MOVE_AVERAGE_ROUND_EN, 0 without.
REQ-032 SHALL cover: clear asserted with data_in_valid on sample 5 -> sample dropped, window_full=0, next valid only after 4 new samples.
REQ-033 SHALL cover: enable=0 in RUN, or rst_n pulse mid-stream -> data_out=0, data_out_valid=0, window_full=0; re-enable needs 4 samples.
